// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the front end.
// Holds address/fetch geometry, the branch-type encoding shared with the BTB,
// and the fetch request bundle handed from PC generation to the I-cache.
package uarch_pkg;

   localparam int CPU_ADDR_BITS     = 32;
   localparam int FETCH_WIDTH       = 2;
   localparam int FETCH_BLOCK_BYTES = 4 * FETCH_WIDTH;
   localparam int SLOT_BITS         = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

   // Branch type as stored in the BTB; the BTB update path uses the same encoding.
   typedef enum logic [1:0] {
      BT_COND = 2'b00,
      BT_JUMP = 2'b01,
      BT_CALL = 2'b10,
      BT_RET  = 2'b11
   } btype_e;

   typedef struct packed {
      logic [CPU_ADDR_BITS-1:0] pc;
      logic [FETCH_WIDTH-1:0]   mask;
      logic                     pred_taken;
      logic [SLOT_BITS-1:0]     pred_slot;
      logic [CPU_ADDR_BITS-1:0] pred_targ;
   } fetch_req_t;

endpackage

// File: rtl/fetch_pc_gen_ras.sv
// Circular return-address stack: push on CALL, pop on RET, top is combinational.
// Latency: push/pop take effect at the next clock edge; top/empty reflect current state.
// Backpressure: none; the caller only pushes/pops on an accepted fetch request.
module ras
   import uarch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [CPU_ADDR_BITS-1:0] push_addr_i,
   output logic [CPU_ADDR_BITS-1:0] top_o,
   output logic                     empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CPU_ADDR_BITS-1:0] ent_q [DEPTH];
   logic [PW-1:0]            ptr_q, ptr_d, ptr_p1, ptr_m1;
   logic [CW-1:0]            cnt_q, cnt_d;

   // ptr_q points at the next slot to write; the top entry sits one below it.
   always_comb begin
      ptr_p1  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      ptr_m1  = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
      top_o   = ent_q[ptr_m1];
      empty_o = (cnt_q == '0);
   end

   // Pointer/count next state; a push onto a full stack silently overwrites the oldest entry.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_i) begin
         ptr_d = ptr_p1;
         if (cnt_q != CW'(DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop_i && !empty_o) begin
         ptr_d = ptr_m1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Pointer and occupancy registers; reset empties the stack.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage needs no reset: the count gates every read.
   always_ff @(posedge clk) begin
      if (push_i) begin
         ent_q[ptr_q] <= push_addr_i;
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Next-fetch-PC generator: holds fetch PC, applies BTB predictions, issues fetch requests.
// Latency: 0 cycles, request is combinational from pc_q and the BTB read data.
// Backpressure: fetch_rdy low holds pc_q and all outputs; a redirect overrides at any time.
// Optional macro FETCH_RAS_EN adds a return-address stack that predicts RET targets.
module fetch_pc_gen
   import uarch_pkg::*;
#(
   parameter logic [CPU_ADDR_BITS-1:0] RESET_VEC = 32'h0000_0000,
   parameter int                       RAS_DEPTH = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   output logic [CPU_ADDR_BITS-1:0]               btb_pc,
   input  logic [FETCH_WIDTH-1:0]                 btb_hit,
   input  logic [FETCH_WIDTH*CPU_ADDR_BITS-1:0]   btb_targs,
   input  logic [2*FETCH_WIDTH-1:0]               btb_types,
   output logic                                   fetch_val,
   input  logic                                   fetch_rdy,
   output logic [CPU_ADDR_BITS-1:0]               fetch_pc,
   output logic [FETCH_WIDTH-1:0]                 fetch_mask,
   output logic                                   fetch_pred_taken,
   output logic [SLOT_BITS-1:0]                   fetch_pred_slot,
   output logic [CPU_ADDR_BITS-1:0]               fetch_pred_targ,
   input  logic                                   redirect_val,
   input  logic [CPU_ADDR_BITS-1:0]               redirect_pc
);

   logic [CPU_ADDR_BITS-1:0] pc_q, pc_d;
   logic                     val_q;
   fetch_req_t               req;
   logic [FETCH_WIDTH-1:0]   base_mask;
   btype_e                   slot_type;
   logic                     handshake;
   logic                     unused_ok;

`ifdef FETCH_RAS_EN
   logic [CPU_ADDR_BITS-1:0] ras_top;
   logic                     ras_empty;
   logic                     ras_push, ras_pop;
   assign unused_ok = ^redirect_pc[1:0];
`else
   assign unused_ok = ^{redirect_pc[1:0], btb_types, RAS_DEPTH};
`endif

   // Build the fetch request: valid slots, first taken slot, and the predicted next PC.
   always_comb begin
      req       = '0;
      base_mask = '0;
      slot_type = BT_COND;
      for (int s = 0; s < FETCH_WIDTH; s++) begin
         base_mask[s] = (s >= int'(pc_q[2 +: SLOT_BITS]));
      end
      req.pc = pc_q;
      for (int s = 0; s < FETCH_WIDTH; s++) begin
         if (!req.pred_taken && base_mask[s] && btb_hit[s]) begin
            req.pred_taken = 1'b1;
            req.pred_slot  = SLOT_BITS'(s);
         end
      end
      for (int s = 0; s < FETCH_WIDTH; s++) begin
         req.mask[s] = base_mask[s] && (!req.pred_taken || (s <= int'(req.pred_slot)));
      end
      slot_type = btype_e'(btb_types[int'(req.pred_slot)*2 +: 2]);
      if (req.pred_taken) begin
         req.pred_targ = btb_targs[int'(req.pred_slot)*CPU_ADDR_BITS +: CPU_ADDR_BITS];
`ifdef FETCH_RAS_EN
         if (slot_type == BT_RET && !ras_empty) begin
            req.pred_targ = ras_top;
         end
`endif
      end else begin
         req.pred_targ = (pc_q & ~CPU_ADDR_BITS'(FETCH_BLOCK_BYTES - 1)) +
                         CPU_ADDR_BITS'(FETCH_BLOCK_BYTES);
      end
      if (!val_q) begin
         req           = '0;
         req.pc        = pc_q;
      end
   end

   assign btb_pc           = pc_q;
   assign fetch_val        = val_q && !redirect_val;
   assign fetch_pc         = req.pc;
   assign fetch_mask       = req.mask;
   assign fetch_pred_taken = req.pred_taken;
   assign fetch_pred_slot  = req.pred_slot;
   assign fetch_pred_targ  = req.pred_targ;
   assign handshake        = fetch_val && fetch_rdy;

`ifdef FETCH_RAS_EN
   assign ras_push = handshake && req.pred_taken && (slot_type == BT_CALL);
   assign ras_pop  = handshake && req.pred_taken && (slot_type == BT_RET) && !ras_empty;

   ras #(
      .DEPTH       (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .push_addr_i ({pc_q[CPU_ADDR_BITS-1:3], req.pred_slot, 2'b00} + CPU_ADDR_BITS'(4)),
      .top_o       (ras_top),
      .empty_o     (ras_empty)
   );
`endif

   // Next PC: redirect beats the handshake; otherwise hold.
   always_comb begin
      pc_d = pc_q;
      if (redirect_val) begin
         pc_d = {redirect_pc[CPU_ADDR_BITS-1:2], 2'b00};
      end else if (handshake) begin
         pc_d = req.pred_targ;
      end
   end

   // Fetch PC and request-valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= {RESET_VEC[CPU_ADDR_BITS-1:2], 2'b00};
         val_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         val_q <= 1'b1;
      end
   end

endmodule
